// File: rtl/score_tally_pkg.sv
`default_nettype none
// ============================================================================
// score_tally_pkg : state type, category ids and saturating add (rev 1.0)
// ============================================================================
package score_tally_pkg;

  typedef enum logic [1:0] {
    COLLECT = 2'd0,
    REPORT  = 2'd1,
    DONE    = 2'd2
  } state_t;

  localparam int CAT_MUX21 = 0;
  localparam int CAT_MUX41 = 1;
  localparam int CAT_FA    = 2;
  localparam int CAT_FA4   = 3;

  // Result never exceeds max_val; widths up to 31 bits are safe.
  function automatic logic [31:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] max_val);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return (sum > {1'b0, max_val}) ? max_val : sum[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/score_tally_if.sv
`default_nettype none
// ============================================================================
// score_tally_if : check-result stream and report-beat channel (rev 1.0)
// ============================================================================
interface score_tally_if #(
  parameter int NUM_CAT = 4,
  parameter int SCORE_W = 8
);
  localparam int CAT_W = $clog2(NUM_CAT);

  logic               chk_valid;
  logic               chk_ready;
  logic [CAT_W-1:0]   chk_cat;
  logic               chk_pass;
  logic               rpt_valid;
  logic               rpt_ready;
  logic [CAT_W-1:0]   rpt_cat;
  logic [SCORE_W-1:0] rpt_score;
  logic               rpt_last;
`ifdef SCORE_TALLY_FAIL_CNT_EN
  logic [SCORE_W-1:0] rpt_fails;

  modport master (output chk_valid, chk_cat, chk_pass, rpt_ready,
                  input  chk_ready, rpt_valid, rpt_cat, rpt_score, rpt_last, rpt_fails);
  modport slave  (input  chk_valid, chk_cat, chk_pass, rpt_ready,
                  output chk_ready, rpt_valid, rpt_cat, rpt_score, rpt_last, rpt_fails);
`else
  modport master (output chk_valid, chk_cat, chk_pass, rpt_ready,
                  input  chk_ready, rpt_valid, rpt_cat, rpt_score, rpt_last);
  modport slave  (input  chk_valid, chk_cat, chk_pass, rpt_ready,
                  output chk_ready, rpt_valid, rpt_cat, rpt_score, rpt_last);
`endif
endinterface
`default_nettype wire

// File: rtl/score_tally_sat_counter.sv
`default_nettype none
// ============================================================================
// sat_counter : clearable counter that clamps at all-ones (rev 1.0)
// ============================================================================
module sat_counter
  import score_tally_pkg::*;
#(
  parameter int SCORE_W = 8
)(
  input  wire logic               clk,
  input  wire logic               rst_n,
  input  wire logic               inc_en,
  input  wire logic [SCORE_W-1:0] inc_amt,
  input  wire logic               clr,
  output logic      [SCORE_W-1:0] count
);
  localparam logic [SCORE_W-1:0] MAX_CNT = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (inc_en)
      count <= SCORE_W'(sat_add(32'(count), 32'(inc_amt), 32'(MAX_CNT)));
  end
endmodule
`default_nettype wire

// File: rtl/score_tally.sv
`default_nettype none
// ============================================================================
// score_tally : per-category pass-point tally with a serial report phase (rev 1.0)
// Optional SCORE_TALLY_FAIL_CNT_EN adds per-category failure counters.
// ============================================================================
module score_tally
  import score_tally_pkg::*;
#(
  parameter int NUM_CAT      = 4,
  parameter int PTS_PER_PASS = 2,
  parameter int SCORE_W      = 8
)(
  input  wire logic               clk,
  input  wire logic               rst_n,
  score_tally_if.slave            bus,
  input  wire logic               done_req,
  input  wire logic               clear,
  output logic      [SCORE_W-1:0] tot_score,
  output logic                    busy,
  output logic                    err_cat
);
  localparam int                 CAT_W    = $clog2(NUM_CAT);
  localparam logic [SCORE_W-1:0] PTS      = SCORE_W'(PTS_PER_PASS);
  localparam logic [SCORE_W-1:0] MAX_CNT  = '1;
  localparam logic [CAT_W-1:0]   LAST_CAT = CAT_W'(NUM_CAT - 1);

  state_t             state, state_nxt;
  logic               accept, cat_ok, rpt_fire, start_rpt;
  logic [CAT_W-1:0]   next_cat;
  logic [NUM_CAT-1:0] pass_inc;
  logic [SCORE_W-1:0] score [NUM_CAT];
  logic [SCORE_W-1:0] beat0_score;

  assign accept        = bus.chk_valid && (state == COLLECT) && !clear;
  assign cat_ok        = ({1'b0, bus.chk_cat} < (CAT_W+1)'(NUM_CAT));
  assign rpt_fire      = bus.rpt_valid && bus.rpt_ready;
  assign start_rpt     = (state == COLLECT) && done_req;
  assign next_cat      = bus.rpt_cat + CAT_W'(1);
  assign bus.chk_ready = (state == COLLECT);
  assign busy          = (state == REPORT);

  generate
    for (genvar i = 0; i < NUM_CAT; i++) begin : g_cat
      assign pass_inc[i] = accept && bus.chk_pass && (bus.chk_cat == CAT_W'(i));
      sat_counter #(.SCORE_W(SCORE_W)) u_score (
        .clk(clk), .rst_n(rst_n), .inc_en(pass_inc[i]), .inc_amt(PTS),
        .clr(clear), .count(score[i]));
    end
  endgenerate

  sat_counter #(.SCORE_W(SCORE_W)) u_total (
    .clk(clk), .rst_n(rst_n), .inc_en(accept && bus.chk_pass && cat_ok),
    .inc_amt(PTS), .clr(clear), .count(tot_score));

  // Beat 0 is loaded on the done_req edge, so fold in a same-cycle pass.
  assign beat0_score = pass_inc[0]
                     ? SCORE_W'(sat_add(32'(score[0]), 32'(PTS), 32'(MAX_CNT)))
                     : score[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= COLLECT;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = COLLECT;
    end else begin
      case (state)
        COLLECT: if (done_req) state_nxt = REPORT;
        REPORT:  if (rpt_fire && bus.rpt_last) state_nxt = DONE;
        DONE:    state_nxt = DONE;
        default: state_nxt = COLLECT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                err_cat <= 1'b0;
    else if (clear)            err_cat <= 1'b0;
    else if (accept && !cat_ok) err_cat <= 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear) begin
      bus.rpt_valid <= 1'b0;
      bus.rpt_cat   <= '0;
      bus.rpt_score <= '0;
      bus.rpt_last  <= 1'b0;
    end else if (start_rpt) begin
      bus.rpt_valid <= 1'b1;
      bus.rpt_cat   <= '0;
      bus.rpt_score <= beat0_score;
      bus.rpt_last  <= 1'b0;
    end else if ((state == REPORT) && rpt_fire) begin
      if (bus.rpt_last) begin
        bus.rpt_valid <= 1'b0;
        bus.rpt_cat   <= '0;
        bus.rpt_score <= '0;
        bus.rpt_last  <= 1'b0;
      end else begin
        bus.rpt_cat   <= next_cat;
        bus.rpt_score <= score[next_cat];
        bus.rpt_last  <= (next_cat == LAST_CAT);
      end
    end
  end

`ifdef SCORE_TALLY_FAIL_CNT_EN
  logic [NUM_CAT-1:0] fail_inc;
  logic [SCORE_W-1:0] fails [NUM_CAT];
  logic [SCORE_W-1:0] beat0_fails;

  generate
    for (genvar i = 0; i < NUM_CAT; i++) begin : g_fail
      assign fail_inc[i] = accept && !bus.chk_pass && (bus.chk_cat == CAT_W'(i));
      sat_counter #(.SCORE_W(SCORE_W)) u_fail (
        .clk(clk), .rst_n(rst_n), .inc_en(fail_inc[i]), .inc_amt(SCORE_W'(1)),
        .clr(clear), .count(fails[i]));
    end
  endgenerate

  assign beat0_fails = fail_inc[0]
                     ? SCORE_W'(sat_add(32'(fails[0]), 32'd1, 32'(MAX_CNT)))
                     : fails[0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || clear)
      bus.rpt_fails <= '0;
    else if (start_rpt)
      bus.rpt_fails <= beat0_fails;
    else if ((state == REPORT) && rpt_fire)
      bus.rpt_fails <= bus.rpt_last ? '0 : fails[next_cat];
  end
`endif
endmodule
`default_nettype wire

// File: tb/tb_score_tally.sv
`default_nettype none
// ============================================================================
// tb_score_tally : directed scoreboard bench for score_tally (rev 1.0)
// ============================================================================
module tb_score_tally;
  import score_tally_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic done_a, clear_a, done_b, clear_b;
  logic [7:0] tot_a;
  logic [3:0] tot_b;
  logic busy_a, busy_b, err_a, err_b;
  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  score_tally_if #(.NUM_CAT(4), .SCORE_W(8)) bus_a ();
  score_tally_if #(.NUM_CAT(3), .SCORE_W(4)) bus_b ();

  score_tally #(.NUM_CAT(4), .PTS_PER_PASS(2), .SCORE_W(8)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .done_req(done_a), .clear(clear_a),
    .tot_score(tot_a), .busy(busy_a), .err_cat(err_a));

  // Narrow instance: 4-bit counters for saturation, 3 categories so an
  // out-of-range category code is representable on the 2-bit port.
  score_tally #(.NUM_CAT(3), .PTS_PER_PASS(2), .SCORE_W(4)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .done_req(done_b), .clear(clear_b),
    .tot_score(tot_b), .busy(busy_b), .err_cat(err_b));

  typedef struct {
    int cat;
    int score;
    int last;
    int fails;
  } beat_t;

  beat_t q[$];
  int sc[4];
  int fl[4];
  int tot_m;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_zero();
    for (int i = 0; i < 4; i++) begin
      sc[i] = 0;
      fl[i] = 0;
    end
    tot_m = 0;
    q.delete();
  endtask

  task automatic push_beats();
    for (int i = 0; i < 4; i++)
      q.push_back('{i, sc[i], int'(i == 3), fl[i]});
  endtask

  // One accepted check on DUT A, optionally together with done_req.
  task automatic a_chk(input int cat, input bit pass, input bit with_done);
    check("a_chk_ready", bus_a.chk_ready, 1);
    bus_a.chk_valid = 1'b1;
    bus_a.chk_cat   = 2'(cat);
    bus_a.chk_pass  = pass;
    done_a          = with_done;
    @(negedge clk);
    bus_a.chk_valid = 1'b0;
    done_a          = 1'b0;
    if (pass) begin
      sc[cat] = sat(sc[cat] + 2, 255);
      tot_m   = sat(tot_m + 2, 255);
    end else begin
      fl[cat] = sat(fl[cat] + 1, 255);
    end
    if (with_done) push_beats();
  endtask

  task automatic a_done();
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    push_beats();
  endtask

  task automatic a_clear();
    clear_a = 1'b1;
    @(negedge clk);
    clear_a = 1'b0;
    model_zero();
  endtask

  // Consume the expected beats; stall beat stall_beat for stall_cyc cycles.
  task automatic a_drain(input int stall_beat, input int stall_cyc);
    int guard;
    int stalled;
    guard   = 0;
    stalled = 0;
    while (q.size() > 0 && guard < 40) begin
      guard++;
      check("rpt_valid", bus_a.rpt_valid, 1);
      check("busy", busy_a, 1);
      check("rpt_cat", bus_a.rpt_cat, q[0].cat);
      check("rpt_score", bus_a.rpt_score, q[0].score);
      check("rpt_last", bus_a.rpt_last, q[0].last);
`ifdef SCORE_TALLY_FAIL_CNT_EN
      check("rpt_fails", bus_a.rpt_fails, q[0].fails);
`endif
      if (q[0].cat == stall_beat && stalled < stall_cyc) begin
        bus_a.rpt_ready = 1'b0;
        stalled++;
      end else begin
        bus_a.rpt_ready = 1'b1;
      end
      @(negedge clk);
      if (bus_a.rpt_ready) void'(q.pop_front());
    end
    bus_a.rpt_ready = 1'b0;
    check("report_beats_left", q.size(), 0);
    check("done_rpt_valid", bus_a.rpt_valid, 0);
    check("done_chk_ready", bus_a.chk_ready, 0);
    check("done_busy", busy_a, 0);
    check("done_tot", tot_a, tot_m);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    done_a = 1'b0; clear_a = 1'b0; done_b = 1'b0; clear_b = 1'b0;
    bus_a.chk_valid = 1'b0; bus_a.chk_cat = '0; bus_a.chk_pass = 1'b0; bus_a.rpt_ready = 1'b0;
    bus_b.chk_valid = 1'b0; bus_b.chk_cat = '0; bus_b.chk_pass = 1'b0; bus_b.rpt_ready = 1'b0;
    model_zero();
    repeat (3) @(negedge clk);

    check("rst_chk_ready", bus_a.chk_ready, 1);
    check("rst_rpt_valid", bus_a.rpt_valid, 0);
    check("rst_rpt_cat", bus_a.rpt_cat, 0);
    check("rst_rpt_score", bus_a.rpt_score, 0);
    check("rst_rpt_last", bus_a.rpt_last, 0);
    check("rst_tot", tot_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_err", err_a, 0);
    check("rst_b_tot", tot_b, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Six passes on the FA category, then a full-rate report.
    for (int i = 0; i < 6; i++) a_chk(CAT_FA, 1'b1, 1'b0);
    check("tot_after_6", tot_a, 12);
    a_done();
    a_drain(-1, 0);

    // done_req in DONE must not restart the report.
    done_a = 1'b1;
    @(negedge clk);
    done_a = 1'b0;
    @(negedge clk);
    check("done_ignored_valid", bus_a.rpt_valid, 0);
    check("done_ignored_ready", bus_a.chk_ready, 0);

    a_clear();
    check("clr_tot", tot_a, 0);
    check("clr_chk_ready", bus_a.chk_ready, 1);

    // Passes then failures on FA4.
    for (int i = 0; i < 10; i++) a_chk(CAT_FA4, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) a_chk(CAT_FA4, 1'b0, 1'b0);
    check("tot_fa4", tot_a, 20);
    a_done();
    a_drain(-1, 0);

    // Pass on MUX41 in the done_req cycle; stall beat 1 for three cycles.
    a_clear();
    a_chk(CAT_MUX41, 1'b1, 1'b1);
    a_drain(CAT_MUX41, 3);

    // clear beats a simultaneous check and done_req.
    a_clear();
    a_chk(CAT_MUX21, 1'b1, 1'b0);
    check("pre_clear_tot", tot_a, 2);
    bus_a.chk_valid = 1'b1; bus_a.chk_cat = 2'(CAT_MUX21); bus_a.chk_pass = 1'b1;
    done_a = 1'b1; clear_a = 1'b1;
    @(negedge clk);
    bus_a.chk_valid = 1'b0; done_a = 1'b0; clear_a = 1'b0;
    model_zero();
    check("clr_prio_tot", tot_a, 0);
    check("clr_prio_collect", bus_a.chk_ready, 1);
    check("clr_prio_valid", bus_a.rpt_valid, 0);

    // Narrow instance: approach and hit saturation.
    for (int i = 0; i < 9; i++) begin
      bus_b.chk_valid = 1'b1; bus_b.chk_cat = 2'd0; bus_b.chk_pass = 1'b1;
      @(negedge clk);
      if (i == 6) check("b_tot_14", tot_b, 14);
    end
    bus_b.chk_valid = 1'b0;
    check("b_tot_sat", tot_b, 15);
    bus_b.chk_valid = 1'b1; bus_b.chk_cat = 2'd3; bus_b.chk_pass = 1'b1;
    @(negedge clk);
    bus_b.chk_valid = 1'b0;
    check("b_err_set", err_b, 1);
    check("b_tot_unchanged", tot_b, 15);
    done_b = 1'b1;
    @(negedge clk);
    done_b = 1'b0;
    check("b_beat0_valid", bus_b.rpt_valid, 1);
    check("b_beat0_cat", bus_b.rpt_cat, 0);
    check("b_beat0_score", bus_b.rpt_score, 15);
    check("b_busy", busy_b, 1);
    clear_b = 1'b1;
    @(negedge clk);
    clear_b = 1'b0;
    check("b_clr_err", err_b, 0);
    check("b_clr_valid", bus_b.rpt_valid, 0);
    check("b_clr_collect", bus_b.chk_ready, 1);
    check("b_clr_tot", tot_b, 0);

    // Asynchronous reset while beat 2 is on the bus.
    a_chk(CAT_MUX21, 1'b1, 1'b0);
    a_chk(CAT_FA, 1'b1, 1'b0);
    a_done();
    bus_a.rpt_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("pre_rst_cat", bus_a.rpt_cat, 2);
    check("pre_rst_valid", bus_a.rpt_valid, 1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", bus_a.rpt_valid, 0);
    check("async_rst_tot", tot_a, 0);
    check("async_rst_busy", busy_a, 0);
    bus_a.rpt_ready = 1'b0;
    model_zero();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_chk_ready", bus_a.chk_ready, 1);
    a_done();
    a_drain(-1, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
`default_nettype wire
